// File: rtl/lcd_vram_arbiter_pkg.sv
// Shared constants, width helpers and write-FSM encoding for the LCD video-RAM arbiter.
package lcd_vram_arbiter_pkg;

  // Number of address bits needed to index 'value' distinct locations.
  function automatic int clogb2(input int unsigned value);
    int unsigned v;
    int res;
    v   = value - 1;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        res++;
        v = v >> 1;
      end
    end
    return res;
  endfunction

  localparam int H_ACT_DEF = 800;
  localparam int V_ACT_DEF = 480;

  localparam int AW = clogb2(H_ACT_DEF * V_ACT_DEF);
  localparam int CW = clogb2(H_ACT_DEF);
  localparam int FW = clogb2(V_ACT_DEF);
  localparam int DW = 24;

  // Idle value of {DEN, HD, VD}: no data enable, syncs deasserted high.
  localparam logic [2:0] SYNC_RST = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } wr_state_t;

endpackage

// File: rtl/lcd_vram_arbiter_sync_delay.sv
// N-stage delay line for {DEN, HD, VD}; also exposes the DEN of stage N-2 for RGB gating.
module lcd_sync_delay
  import lcd_vram_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic       NCLK,
  input  logic       GREST,
  input  logic [2:0] sync_in,
  output logic [2:0] sync_out,
  output logic       den_tap
);

  logic [3*N-1:0] pipe;

  always_ff @(posedge NCLK or negedge GREST) begin
    if (!GREST) begin
      pipe <= {N{SYNC_RST}};
    end else begin
      pipe <= {pipe[3*N-4:0], sync_in};
    end
  end

  assign sync_out = pipe[3*N-1 -: 3];
  // DEN one stage before the output, so the RGB register lands in step with sync_out.
  assign den_tap  = pipe[3*N-4];

endmodule

// File: rtl/lcd_vram_arbiter.sv
// Shares one single-port video RAM between LCD scan-out (priority) and a req/ack pixel writer.
module lcd_vram_arbiter
  import lcd_vram_arbiter_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF
) (
  input  logic          NCLK,
  input  logic          GREST,
  input  logic          DEN_in,
  input  logic          HD_in,
  input  logic          VD_in,
  input  logic [CW-1:0] columna,
  input  logic [FW-1:0] fila,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          DEN,
  output logic          HD,
  output logic          VD
);

  localparam logic [AW:0] NPIX = (AW+1)'(H_ACT * V_ACT);

  logic [AW-1:0] fila_w;
  logic [AW-1:0] col_w;
  logic [AW-1:0] row_base;
  logic [AW-1:0] pix_addr;

  assign fila_w = AW'(fila);
  assign col_w  = AW'(columna);

  // Row base as a constant shift-add so no multiplier is inferred.
  generate
    if (H_ACT == 800) begin : g_800
      assign row_base = (fila_w << 9) + (fila_w << 8) + (fila_w << 5);
    end else begin : g_generic
      always_comb begin
        row_base = '0;
        for (int i = 0; i < 32; i++) begin
          if (H_ACT[i]) row_base = row_base + (fila_w << i);
        end
      end
    end
  endgenerate

  assign pix_addr = row_base + col_w;

  logic          den_s;
  logic          hd_s;
  logic          vd_s;
  logic          req_s;
  logic [AW-1:0] rd_addr_s;
  logic [AW-1:0] wa_s;
  logic [DW-1:0] wd_s;

  always_ff @(posedge NCLK or negedge GREST) begin
    if (!GREST) begin
      den_s     <= 1'b0;
      hd_s      <= 1'b1;
      vd_s      <= 1'b1;
      req_s     <= 1'b0;
      rd_addr_s <= '0;
      wa_s      <= '0;
      wd_s      <= '0;
    end else begin
      den_s     <= DEN_in;
      hd_s      <= HD_in;
      vd_s      <= VD_in;
      req_s     <= wr_req;
      rd_addr_s <= pix_addr;
      wa_s      <= wr_addr;
      wd_s      <= wr_data;
    end
  end

  wr_state_t state;
  logic      wa_bad;

  assign wa_bad = ({1'b0, wa_s} >= NPIX);

  // Slot owner per cycle: display read first, then a single write per request.
  always_ff @(posedge NCLK or negedge GREST) begin
    if (!GREST) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      if (den_s) mem_addr <= rd_addr_s;
      case (state)
        ST_IDLE: begin
          if (req_s && !den_s) begin
            wr_ack <= 1'b1;
            wr_err <= wa_bad;
            if (!wa_bad) begin
              mem_we    <= 1'b1;
              mem_addr  <= wa_s;
              mem_wdata <= wd_s;
            end
            state <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_WAIT;
        ST_WAIT: if (!req_s) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [2:0] sync_d;
  logic       den_tap;

  lcd_sync_delay #(.N(3)) u_sync_delay (
    .NCLK    (NCLK),
    .GREST   (GREST),
    .sync_in ({den_s, hd_s, vd_s}),
    .sync_out(sync_d),
    .den_tap (den_tap)
  );

  assign {DEN, HD, VD} = sync_d;

  logic [DW-1:0] rgb_reg;

  always_ff @(posedge NCLK or negedge GREST) begin
    if (!GREST) begin
      rgb_reg <= '0;
    end else begin
      rgb_reg <= den_tap ? mem_rdata : '0;
    end
  end

  assign R = rgb_reg[23:16];
  assign G = rgb_reg[15:8];
  assign B = rgb_reg[7:0];

endmodule
